data_bus_arbiter: RTL and testbench
===================================

Name: data_bus_arbiter

Overview:
- Shares one data memory port (req/gnt/rvalid protocol) between two masters: master 0 is the core data port, master 1 is a secondary master (DMA or debug loader).
- Sits between the core's data interface and the data memory.
- Has at most one transaction outstanding at a time.
- Uses round-robin on contention and a response timeout that returns an error to the master that is waiting.

Parameters:
- ADDR_WIDTH, 32, width of the address buses
- DATA_WIDTH, 32, width of the read and write data buses
- XFER_WIDTH, 2, width of the write-transfer size code
- TIMEOUT, 255, number of RESP cycles without s_rvalid_i before an error response; 0 disables the timeout

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- m0_req_i  input  1  master 0 request
- m0_gnt_o  output  1  master 0 grant
- m0_addr_i  input  ADDR_WIDTH  master 0 address
- m0_wr_i  input  1  master 0 write (1) / read (0)
- m0_wdata_i  input  DATA_WIDTH  master 0 write data
- m0_xfer_i  input  XFER_WIDTH  master 0 transfer size
- m0_rdata_o  output  DATA_WIDTH  master 0 read data
- m0_rvalid_o  output  1  master 0 response valid
- m0_err_o  output  1  master 0 timeout error, qualified by m0_rvalid_o
- m1_*  same set of ports as m0_*, for master 1
- s_req_o  output  1  slave request
- s_gnt_i  input  1  slave grant
- s_addr_o  output  ADDR_WIDTH  slave address
- s_wr_o  output  1  slave write
- s_wdata_o  output  DATA_WIDTH  slave write data
- s_xfer_o  output  XFER_WIDTH  slave transfer size
- s_rdata_i  input  DATA_WIDTH  slave read data
- s_rvalid_i  input  1  slave response valid; one per granted transaction, for reads and writes

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, sel=0, last=1 (master 0 wins the first tie), timeout counter=0.
  - All outputs 0.
  - Takes effect immediately, including mid-transaction; any in-flight transaction is abandoned.
- Master protocol: a master holds req and all its attributes stable from assertion until its gnt is sampled high.
- State IDLE:
  - s_req_o=0 and all m*_gnt_o=0.
  - If exactly one m*_req_i is high, sel is set to that master.
  - If both are high, sel is set to the master other than last.
  - Next state is REQ. With no request, stay in IDLE.
- State REQ:
  - s_req_o=1.
  - s_addr_o, s_wr_o, s_wdata_o and s_xfer_o are combinationally muxed from master sel.
  - m<sel>_gnt_o = s_gnt_i (combinational); the other master's gnt is 0.
  - When s_gnt_i is sampled high: next state is RESP, last is set to sel, counter cleared.
  - When s_gnt_i is low: stay in REQ with no limit.
- Slave outputs outside REQ: s_addr_o, s_wr_o, s_wdata_o and s_xfer_o are driven 0.
- State RESP:
  - s_req_o=0.
  - On s_rvalid_i=1: m<sel>_rvalid_o=1 and m<sel>_rdata_o=s_rdata_i (combinational pass-through), err=0, next state IDLE.
  - Otherwise the counter increments.
  - If TIMEOUT!=0 and the counter equals TIMEOUT-1 with no s_rvalid_i: m<sel>_rvalid_o=1, m<sel>_err_o=1, m<sel>_rdata_o=0 for that cycle, next state IDLE.
  - s_rvalid_i and the timeout in the same cycle: the real response wins, err=0.
- Non-selected master: rvalid, rdata, err and gnt are held 0.
- Stray responses: s_rvalid_i in IDLE or REQ (e.g. a late response after a timeout) is ignored and not routed to any master.
- Latency:
  - Request (IDLE) to s_req_o: 1 cycle.
  - s_gnt_i to earliest m_rvalid_o: 1 cycle (s_rvalid_i seen in RESP).
  - Minimum gap between back-to-back transactions: one IDLE cycle.
- Fairness: with both masters requesting continuously, grants alternate 0,1,0,1.
- Counter width: clog2(TIMEOUT+1); it never wraps because it is cleared on entry to RESP.

Test Plan:
1. Single read: m0_req with addr 0x100; slave gnt in the same cycle as s_req_o and rvalid 2 cycles later with 0xDEADBEEF.
   - s_req_o high 1 cycle after m0_req.
   - m0_gnt_o pulses with s_gnt_i.
   - m0_rvalid_o=1 and m0_rdata_o=0xDEADBEEF; m1 outputs stay 0.
2. Contention: both masters request from reset, with requests held high.
   - Order of service is m0, m1, m0, m1.
   - Each s_addr_o matches the served master.
3. Delayed grant: s_gnt_i held low for 5 cycles.
   - s_req_o stays high and attributes stay stable for 5 cycles.
   - No m_gnt before s_gnt_i.
4. Timeout: TIMEOUT=4, no rvalid after grant.
   - On the 4th RESP cycle the served master gets rvalid=1, err=1, rdata=0.
   - A later s_rvalid_i arriving in IDLE is ignored.
5. Timeout/response collision: s_rvalid_i arrives exactly on the timeout cycle.
   - rvalid=1, err=0, rdata equals s_rdata_i.
6. Reset mid-operation: rst_n dropped while in RESP.
   - All outputs go to 0 asynchronously.
   - After release, simultaneous requests grant m0 first.

Source files
------------

// File: rtl/data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_arbiter
// Brief    : Two-master round-robin arbiter for a req/gnt/rvalid data memory
//            port with one outstanding transaction and a response timeout.
// Revision : 1.0
// ============================================================================
module data_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int XFER_WIDTH = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  m0_req_i,
  output logic                  m0_gnt_o,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                  m0_wr_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  input  logic [XFER_WIDTH-1:0] m0_xfer_i,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  output logic                  m0_rvalid_o,
  output logic                  m0_err_o,

  input  logic                  m1_req_i,
  output logic                  m1_gnt_o,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                  m1_wr_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  input  logic [XFER_WIDTH-1:0] m1_xfer_i,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  m1_rvalid_o,
  output logic                  m1_err_o,

  output logic                  s_req_o,
  input  logic                  s_gnt_i,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic                  s_wr_o,
  output logic [DATA_WIDTH-1:0] s_wdata_o,
  output logic [XFER_WIDTH-1:0] s_xfer_o,
  input  logic [DATA_WIDTH-1:0] s_rdata_i,
  input  logic                  s_rvalid_i
);

  localparam int              c_CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int              c_TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(c_TO_LAST_I);
  localparam logic            c_TO_EN     = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_sel;
  logic                 r_last;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 w_timeout;

  // A real response in the timeout cycle takes priority over the error.
  assign w_timeout = c_TO_EN && (r_state == S_RESP) && !s_rvalid_i && (r_cnt == c_TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (m0_req_i && m1_req_i) begin
            r_sel   <= ~r_last;
            r_state <= S_REQ;
          end else if (m0_req_i) begin
            r_sel   <= 1'b0;
            r_state <= S_REQ;
          end else if (m1_req_i) begin
            r_sel   <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (s_gnt_i) begin
            r_state <= S_RESP;
            r_last  <= r_sel;
            r_cnt   <= '0;
          end
        end
        S_RESP: begin
          if (s_rvalid_i || w_timeout) begin
            r_state <= S_IDLE;
          end else if (c_TO_EN) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    s_req_o     = 1'b0;
    s_addr_o    = '0;
    s_wr_o      = 1'b0;
    s_wdata_o   = '0;
    s_xfer_o    = '0;
    m0_gnt_o    = 1'b0;
    m1_gnt_o    = 1'b0;
    m0_rvalid_o = 1'b0;
    m1_rvalid_o = 1'b0;
    m0_err_o    = 1'b0;
    m1_err_o    = 1'b0;
    m0_rdata_o  = '0;
    m1_rdata_o  = '0;
    case (r_state)
      S_REQ: begin
        s_req_o = 1'b1;
        if (r_sel) begin
          s_addr_o  = m1_addr_i;
          s_wr_o    = m1_wr_i;
          s_wdata_o = m1_wdata_i;
          s_xfer_o  = m1_xfer_i;
          m1_gnt_o  = s_gnt_i;
        end else begin
          s_addr_o  = m0_addr_i;
          s_wr_o    = m0_wr_i;
          s_wdata_o = m0_wdata_i;
          s_xfer_o  = m0_xfer_i;
          m0_gnt_o  = s_gnt_i;
        end
      end
      S_RESP: begin
        if (s_rvalid_i) begin
          if (r_sel) begin
            m1_rvalid_o = 1'b1;
            m1_rdata_o  = s_rdata_i;
          end else begin
            m0_rvalid_o = 1'b1;
            m0_rdata_o  = s_rdata_i;
          end
        end else if (w_timeout) begin
          if (r_sel) begin
            m1_rvalid_o = 1'b1;
            m1_err_o    = 1'b1;
          end else begin
            m0_rvalid_o = 1'b1;
            m0_err_o    = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_bus_arbiter
// Brief    : Self-checking bench for data_bus_arbiter (vectors, corner cases,
//            randomized traffic against a transaction-level reference model).
// Revision : 1.0
// ============================================================================
module tb_data_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int XW = 2;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0]         req;
  logic [1:0]         wr;
  logic [1:0][AW-1:0] addr;
  logic [1:0][DW-1:0] wdata;
  logic [1:0][XW-1:0] xfer;
  logic               s_gnt;
  logic               s_rvalid;
  logic [DW-1:0]      s_rdata;

  wire [1:0]          gnt;
  wire [1:0]          rvalid;
  wire [1:0]          err;
  wire [DW-1:0]       rdata0;
  wire [DW-1:0]       rdata1;
  wire                s_req;
  wire                s_wr;
  wire [AW-1:0]       s_addr;
  wire [DW-1:0]       s_wdata;
  wire [XW-1:0]       s_xfer;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_bus_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .XFER_WIDTH(XW), .TIMEOUT(TO)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(req[0]), .m0_gnt_o(gnt[0]), .m0_addr_i(addr[0]), .m0_wr_i(wr[0]),
    .m0_wdata_i(wdata[0]), .m0_xfer_i(xfer[0]), .m0_rdata_o(rdata0),
    .m0_rvalid_o(rvalid[0]), .m0_err_o(err[0]),
    .m1_req_i(req[1]), .m1_gnt_o(gnt[1]), .m1_addr_i(addr[1]), .m1_wr_i(wr[1]),
    .m1_wdata_i(wdata[1]), .m1_xfer_i(xfer[1]), .m1_rdata_o(rdata1),
    .m1_rvalid_o(rvalid[1]), .m1_err_o(err[1]),
    .s_req_o(s_req), .s_gnt_i(s_gnt), .s_addr_o(s_addr), .s_wr_o(s_wr),
    .s_wdata_o(s_wdata), .s_xfer_o(s_xfer), .s_rdata_i(s_rdata), .s_rvalid_i(s_rvalid)
  );

  typedef struct {
    logic          s_req;
    logic [AW-1:0] s_addr;
    logic          s_wr;
    logic [DW-1:0] s_wdata;
    logic [XW-1:0] s_xfer;
    logic [1:0]    gnt;
    logic [1:0]    rvalid;
    logic [1:0]    err;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
  } out_t;

  typedef struct {
    logic          m0_req;
    logic [AW-1:0] m0_addr;
    logic          m1_req;
    logic [AW-1:0] m1_addr;
    logic          sg;
    logic          sv;
    logic [DW-1:0] sd;
    logic          e_sreq;
    logic [AW-1:0] e_saddr;
    logic [1:0]    e_gnt;
    logic [1:0]    e_rvalid;
    logic [DW-1:0] e_rdata;
  } vec_t;

  // Reference model: bus free / offering to a master / awaiting its response.
  int ph, who, prev, waited;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic out_t zero_out();
    out_t o;
    o.s_req = 1'b0; o.s_addr = '0; o.s_wr = 1'b0; o.s_wdata = '0; o.s_xfer = '0;
    o.gnt = '0; o.rvalid = '0; o.err = '0; o.rdata0 = '0; o.rdata1 = '0;
    return o;
  endfunction

  function automatic out_t dut_out();
    out_t o;
    o.s_req = s_req; o.s_addr = s_addr; o.s_wr = s_wr; o.s_wdata = s_wdata;
    o.s_xfer = s_xfer; o.gnt = gnt; o.rvalid = rvalid; o.err = err;
    o.rdata0 = rdata0; o.rdata1 = rdata1;
    return o;
  endfunction

  function automatic out_t model_out();
    out_t o;
    logic [DW-1:0] d;
    o = zero_out();
    d = '0;
    if (ph == 1) begin
      o.s_req   = 1'b1;
      o.s_addr  = addr[who];
      o.s_wr    = wr[who];
      o.s_wdata = wdata[who];
      o.s_xfer  = xfer[who];
      o.gnt[who] = s_gnt;
    end else if (ph == 2) begin
      if (s_rvalid) begin
        o.rvalid[who] = 1'b1;
        d = s_rdata;
      end else if (TO != 0 && waited + 1 == TO) begin
        o.rvalid[who] = 1'b1;
        o.err[who]    = 1'b1;
      end
      if (who == 0) o.rdata0 = d; else o.rdata1 = d;
    end
    return o;
  endfunction

  task automatic model_reset();
    ph = 0; who = 0; prev = 1; waited = 0;
  endtask

  task automatic model_step();
    if (ph == 0) begin
      if (req[0] && req[1]) begin who = 1 - prev; ph = 1; end
      else if (req[0])      begin who = 0; ph = 1; end
      else if (req[1])      begin who = 1; ph = 1; end
    end else if (ph == 1) begin
      if (s_gnt) begin ph = 2; prev = who; waited = 0; end
    end else begin
      if (s_rvalid || (TO != 0 && waited + 1 == TO)) ph = 0;
      else waited++;
    end
  endtask

  task automatic compare(input out_t a, input out_t e, input string tag);
    chk({tag, ".s_req"},   64'(a.s_req),   64'(e.s_req));
    chk({tag, ".s_addr"},  64'(a.s_addr),  64'(e.s_addr));
    chk({tag, ".s_wr"},    64'(a.s_wr),    64'(e.s_wr));
    chk({tag, ".s_wdata"}, 64'(a.s_wdata), 64'(e.s_wdata));
    chk({tag, ".s_xfer"},  64'(a.s_xfer),  64'(e.s_xfer));
    chk({tag, ".gnt"},     64'(a.gnt),     64'(e.gnt));
    chk({tag, ".rvalid"},  64'(a.rvalid),  64'(e.rvalid));
    chk({tag, ".err"},     64'(a.err),     64'(e.err));
    chk({tag, ".rdata0"},  64'(a.rdata0),  64'(e.rdata0));
    chk({tag, ".rdata1"},  64'(a.rdata1),  64'(e.rdata1));
  endtask

  // Inputs are set just after a rising edge; outputs are sampled on the falling edge.
  task automatic tick(input bit use_model, output out_t act, output out_t exp);
    @(negedge clk);
    exp = model_out();
    act = dut_out();
    if (use_model) compare(act, exp, "model");
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    req = '0; wr = '0; addr = '0; wdata = '0; xfer = '0;
    s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    compare(dut_out(), zero_out(), "reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic m0r, logic [AW-1:0] m0a, logic m1r, logic [AW-1:0] m1a,
                              logic sg, logic sv, logic [DW-1:0] sd, logic esr,
                              logic [AW-1:0] esa, logic [1:0] eg, logic [1:0] ev,
                              logic [DW-1:0] ed);
    vec_t v;
    v.m0_req = m0r; v.m0_addr = m0a; v.m1_req = m1r; v.m1_addr = m1a;
    v.sg = sg; v.sv = sv; v.sd = sd; v.e_sreq = esr; v.e_saddr = esa;
    v.e_gnt = eg; v.e_rvalid = ev; v.e_rdata = ed;
    return v;
  endfunction

  initial begin
    vec_t tbl [14];
    out_t a, e;

    tbl[0]  = mk(1, 32'h100, 0, 0,       0, 0, 0,            0, 0,       2'b00, 2'b00, 0);
    tbl[1]  = mk(1, 32'h100, 0, 0,       1, 0, 0,            1, 32'h100, 2'b01, 2'b00, 0);
    tbl[2]  = mk(0, 0,       0, 0,       1, 0, 0,            0, 0,       2'b00, 2'b00, 0);
    tbl[3]  = mk(0, 0,       0, 0,       0, 1, 32'hDEADBEEF, 0, 0,       2'b00, 2'b01, 32'hDEADBEEF);
    tbl[4]  = mk(0, 0,       0, 0,       0, 1, 32'h1234,     0, 0,       2'b00, 2'b00, 0);
    tbl[5]  = mk(0, 0,       1, 32'h200, 1, 0, 0,            0, 0,       2'b00, 2'b00, 0);
    tbl[6]  = mk(0, 0,       1, 32'h200, 0, 0, 0,            1, 32'h200, 2'b00, 2'b00, 0);
    tbl[7]  = mk(0, 0,       1, 32'h200, 0, 1, 32'h5555,     1, 32'h200, 2'b00, 2'b00, 0);
    tbl[8]  = mk(0, 0,       1, 32'h200, 0, 0, 0,            1, 32'h200, 2'b00, 2'b00, 0);
    tbl[9]  = mk(0, 0,       1, 32'h200, 0, 0, 0,            1, 32'h200, 2'b00, 2'b00, 0);
    tbl[10] = mk(0, 0,       1, 32'h200, 0, 0, 0,            1, 32'h200, 2'b00, 2'b00, 0);
    tbl[11] = mk(0, 0,       1, 32'h200, 1, 0, 0,            1, 32'h200, 2'b10, 2'b00, 0);
    tbl[12] = mk(0, 0,       0, 0,       0, 1, 32'hCAFE0001, 0, 0,       2'b00, 2'b10, 32'hCAFE0001);
    tbl[13] = mk(0, 0,       0, 0,       0, 0, 0,            0, 0,       2'b00, 2'b00, 0);

    clear_inputs();
    model_reset();
    #2;
    compare(dut_out(), zero_out(), "reset0");
    do_reset();

    // Single read followed by a delayed grant with stray responses.
    for (int i = 0; i < 14; i++) begin
      req     = {tbl[i].m1_req, tbl[i].m0_req};
      addr[0] = tbl[i].m0_addr;
      addr[1] = tbl[i].m1_addr;
      s_gnt   = tbl[i].sg;
      s_rvalid = tbl[i].sv;
      s_rdata = tbl[i].sd;
      tick(1'b0, a, e);
      chk($sformatf("row%0d.s_req", i),  64'(a.s_req),  64'(tbl[i].e_sreq));
      chk($sformatf("row%0d.s_addr", i), 64'(a.s_addr), 64'(tbl[i].e_saddr));
      chk($sformatf("row%0d.gnt", i),    64'(a.gnt),    64'(tbl[i].e_gnt));
      chk($sformatf("row%0d.rvalid", i), 64'(a.rvalid), 64'(tbl[i].e_rvalid));
      chk($sformatf("row%0d.err", i),    64'(a.err),    64'(0));
      chk($sformatf("row%0d.rdata0", i), 64'(a.rdata0), 64'(tbl[i].e_rvalid[0] ? tbl[i].e_rdata : 0));
      chk($sformatf("row%0d.rdata1", i), 64'(a.rdata1), 64'(tbl[i].e_rvalid[1] ? tbl[i].e_rdata : 0));
    end

    // Contention from reset: service order must alternate starting with m0.
    do_reset();
    req = 2'b11; addr[0] = 32'h1000; addr[1] = 32'h2000;
    wr = 2'b10; wdata[0] = 32'h11; wdata[1] = 32'h22; xfer[0] = 2'd1; xfer[1] = 2'd2;
    s_gnt = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h77;
    for (int t = 0; t < 12; t++) begin
      tick(1'b1, a, e);
      if (t % 3 == 1) begin
        chk($sformatf("rr%0d.s_addr", t / 3), 64'(a.s_addr), 64'(addr[(t / 3) % 2]));
        chk($sformatf("rr%0d.gnt", t / 3),    64'(a.gnt),    64'(2'b01 << ((t / 3) % 2)));
      end
    end

    // Timeout: the 4th response cycle without s_rvalid returns an error.
    clear_inputs();
    req = 2'b01; addr[0] = 32'h3000; s_gnt = 1'b1; s_rdata = 32'hFFFFFFFF;
    tick(1'b1, a, e);
    tick(1'b1, a, e);
    req = 2'b00; s_gnt = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick(1'b1, a, e);
      chk($sformatf("to.rvalid%0d", c), 64'(a.rvalid), 64'(c == 4 ? 2'b01 : 2'b00));
      chk($sformatf("to.err%0d", c),    64'(a.err),    64'(c == 4 ? 2'b01 : 2'b00));
      chk($sformatf("to.rdata%0d", c),  64'(a.rdata0), 64'(0));
    end
    s_rvalid = 1'b1;
    tick(1'b1, a, e);
    chk("to.late_rvalid", 64'(a.rvalid), 64'(0));

    // Real response in the timeout cycle wins.
    clear_inputs();
    req = 2'b10; addr[1] = 32'h4000; s_gnt = 1'b1;
    tick(1'b1, a, e);
    tick(1'b1, a, e);
    req = 2'b00; s_gnt = 1'b0;
    for (int c = 1; c <= 3; c++) tick(1'b1, a, e);
    s_rvalid = 1'b1; s_rdata = 32'hA5A5A5A5;
    tick(1'b1, a, e);
    chk("col.rvalid", 64'(a.rvalid), 64'(2'b10));
    chk("col.err",    64'(a.err),    64'(2'b00));
    chk("col.rdata",  64'(a.rdata1), 64'(32'hA5A5A5A5));

    // Asynchronous reset while awaiting a response from m0.
    clear_inputs();
    req = 2'b01; addr[0] = 32'h5000; s_gnt = 1'b1;
    tick(1'b1, a, e);
    tick(1'b1, a, e);
    req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h13572468;
    #1;
    chk("rst.pre_rvalid", 64'(rvalid), 64'(2'b01));
    rst_n = 1'b0;
    #1;
    compare(dut_out(), zero_out(), "rst.async");
    model_reset();
    s_rvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    req = 2'b11; addr[0] = 32'h6000; addr[1] = 32'h7000; s_gnt = 1'b1;
    tick(1'b1, a, e);
    tick(1'b1, a, e);
    chk("rst.first_gnt",  64'(a.gnt),    64'(2'b01));
    chk("rst.first_addr", 64'(a.s_addr), 64'(32'h6000));

    // Randomized traffic against the reference model.
    clear_inputs();
    for (int n = 0; n < 3000; n++) begin
      s_gnt    = 1'($urandom);
      s_rvalid = ($urandom_range(0, 3) == 0);
      s_rdata  = $urandom;
      for (int i = 0; i < 2; i++) begin
        if (!req[i] && ($urandom_range(0, 1) == 1)) begin
          req[i] = 1'b1; addr[i] = $urandom; wr[i] = 1'($urandom);
          wdata[i] = $urandom; xfer[i] = XW'($urandom);
        end
      end
      tick(1'b1, a, e);
      for (int i = 0; i < 2; i++) begin
        if (req[i] && e.gnt[i]) begin
          req[i] = 1'($urandom);
          addr[i] = $urandom; wr[i] = 1'($urandom);
          wdata[i] = $urandom; xfer[i] = XW'($urandom);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
